instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage directly downstream of the program counter. It takes the current instruction PC when control signals a fetch and issues a single-beat read on the instruction memory port using a request/acknowledge handshake. It captures the returned word and presents it, tagged with its PC, to decode through a valid/consume handshake. It also detects misaligned PCs and memory-acknowledge timeouts and reports them as sticky faults.

Parameters:
RESET_INSTRUCTION, 32'h00000013, word presented on instruction while nothing is valid (RV32I NOP).
ACK_TIMEOUT, 16, maximum cycles to wait for memReadAck; 0 disables the timeout.

Ports:
clock  input  1  single clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
pcOfInstruction  input  32  current PC from the program counter.
fetchStart  input  1  request to fetch at pcOfInstruction; sampled only in IDLE, or in HOLD together with instructionConsume.
flush  input  1  synchronous abort; discards any in-flight or held fetch and clears faults.
memReadAddress  output  32  word address to instruction memory.
memReadRequest  output  1  read request; held high until acknowledged.
memReadAck  input  1  memory acknowledge; meaningful only while memReadRequest=1.
memReadData  input  32  read data, valid when memReadAck=1.
instruction  output  32  fetched instruction word.
instructionPC  output  32  PC the instruction was fetched from.
instructionValid  output  1  instruction/instructionPC are valid.
instructionConsume  input  1  decode accepts the instruction this cycle.
fetchMisaligned  output  1  sticky: fetch was attempted at a PC with pc[1:0]!=0.
fetchTimeout  output  1  sticky: no memReadAck within ACK_TIMEOUT cycles.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; memReadRequest=0; memReadAddress=0; instruction=RESET_INSTRUCTION; instructionPC=0; instructionValid=0; both faults=0; timeout counter=0.
- States: IDLE, WAIT, HOLD, FAULT.
- IDLE behaviour on fetchStart=1:
  - pcOfInstruction[1:0]!=0: go to FAULT, set fetchMisaligned=1 on the next edge, issue no request.
  - Otherwise: latch memReadAddress=pcOfInstruction, set memReadRequest=1, go to WAIT.
- WAIT behaviour:
  - memReadRequest and memReadAddress are held stable.
  - memReadAck=1: on that edge capture instruction=memReadData and instructionPC=memReadAddress, set instructionValid=1 and memReadRequest=0, go to HOLD.
  - Timeout: counter increments each WAIT cycle without an ack. When it reaches ACK_TIMEOUT (and ACK_TIMEOUT!=0), drop memReadRequest, set fetchTimeout=1, go to FAULT.
  - The counter clears on entry to WAIT. An ack in the same cycle the counter expires wins.
- HOLD behaviour:
  - Outputs stay stable while instructionConsume=0.
  - instructionConsume=1 and fetchStart=0: instructionValid=0, instruction returns to RESET_INSTRUCTION, go to IDLE.
  - instructionConsume=1 and fetchStart=1: back-to-back fetch. Apply the IDLE rules to the new PC in the same edge, and instructionValid drops.
  - instructionConsume while instructionValid=0 is ignored.
- FAULT behaviour: outputs idle and faults held until flush; fetchStart is ignored.
- flush=1 (priority over all except reset): on the next edge go to IDLE, memReadRequest=0, instructionValid=0, faults cleared. An ack arriving in the same cycle as flush is discarded. memReadAck while memReadRequest=0 is ignored.
- Latency: fetchStart at edge N gives memReadRequest high after N. With an ack in the first request cycle (sampled at N+1), instructionValid is high after N+1. Minimum PC-to-valid latency is 2 edges.
- memReadRequest never deasserts without an ack, except on timeout, flush or reset.

Decomposition:
- Package instruction_fetch_pkg:
  - fetch_state_t enum {IDLE, WAIT, HOLD, FAULT}.
  - RV32I NOP constant 32'h00000013.
  - Alignment-check function.
- One sub-module: fetch_timeout_counter.
  - Parameter ACK_TIMEOUT.
  - Inputs: clock, reset, clear, enable.
  - Output: expired.
  - Width $clog2(ACK_TIMEOUT+1).

Test Plan:
- Reset mid-WAIT at PC=0x100 → next cycle: memReadRequest=0, instructionValid=0, instruction=0x00000013, state IDLE.
- fetchStart with PC=0x00000040, ack in first request cycle with data 0x00500093 → memReadAddress=0x40 for one cycle; next cycle instruction=0x00500093, instructionPC=0x40, instructionValid=1; held until consume.
- PC=0x00000042, fetchStart → no request ever issued, fetchMisaligned=1 sticky; flush clears it and a subsequent fetch at 0x44 succeeds.
- ACK_TIMEOUT=4, no ack → memReadRequest high for exactly 4 cycles then low, fetchTimeout=1; an ack injected on the 4th cycle instead gives valid data and no fault.
- HOLD with consume=1 and fetchStart=1 at PC=0x48, 3-cycle ack latency → request issued on the same edge valid drops; new instruction valid 4 edges later with instructionPC=0x48.
- flush asserted in the same cycle as memReadAck (data 0xDEADBEEF) → instructionValid stays 0, IDLE next cycle, a stray ack afterwards is ignored.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  function automatic logic isWordAligned(input logic [31:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Control, memory-port and decode-side signals of the fetch stage.
interface instruction_fetch_if;
  logic [31:0] pcOfInstruction;
  logic        fetchStart;
  logic        flush;
  logic [31:0] memReadAddress;
  logic        memReadRequest;
  logic        memReadAck;
  logic [31:0] memReadData;
  logic [31:0] instruction;
  logic [31:0] instructionPC;
  logic        instructionValid;
  logic        instructionConsume;
  logic        fetchMisaligned;
  logic        fetchTimeout;

  modport master (
    input  pcOfInstruction, fetchStart, flush, memReadAck, memReadData,
           instructionConsume,
    output memReadAddress, memReadRequest, instruction, instructionPC,
           instructionValid, fetchMisaligned, fetchTimeout
  );

  modport slave (
    output pcOfInstruction, fetchStart, flush, memReadAck, memReadData,
           instructionConsume,
    input  memReadAddress, memReadRequest, instruction, instructionPC,
           instructionValid, fetchMisaligned, fetchTimeout
  );
endinterface

// File: rtl/instruction_fetch_timeout_counter.sv
// Counts WAIT cycles without an acknowledge; expired flags the cycle whose
// increment would reach ACK_TIMEOUT.
module fetch_timeout_counter #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : '0;

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (ACK_TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues one read per fetch, holds the returned word for decode,
// and reports misaligned PCs and acknowledge timeouts as sticky faults.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_INSTRUCTION = RV32I_NOP,
  parameter int unsigned ACK_TIMEOUT       = 16
) (
  input logic             clock,
  input logic             reset,
  instruction_fetch_if.master bus
);

  fetch_state_t state, stateNext;

  logic [31:0] addrReg, addrNext;
  logic        reqReg, reqNext;
  logic [31:0] instrReg, instrNext;
  logic [31:0] pcReg, pcNext;
  logic        validReg, validNext;
  logic        misReg, misNext;
  logic        toReg, toNext;
  logic        expired;

  fetch_timeout_counter #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) timeoutCounter (
    .clock  (clock),
    .reset  (reset),
    .clear  (state != WAIT),
    .enable (state == WAIT && !bus.memReadAck && !bus.flush),
    .expired(expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addrReg  <= '0;
      reqReg   <= 1'b0;
      instrReg <= RESET_INSTRUCTION;
      pcReg    <= '0;
      validReg <= 1'b0;
      misReg   <= 1'b0;
      toReg    <= 1'b0;
    end else begin
      state    <= stateNext;
      addrReg  <= addrNext;
      reqReg   <= reqNext;
      instrReg <= instrNext;
      pcReg    <= pcNext;
      validReg <= validNext;
      misReg   <= misNext;
      toReg    <= toNext;
    end
  end

  always_comb begin
    stateNext = state;
    addrNext  = addrReg;
    reqNext   = reqReg;
    instrNext = instrReg;
    pcNext    = pcReg;
    validNext = validReg;
    misNext   = misReg;
    toNext    = toReg;

    if (bus.flush) begin
      stateNext = IDLE;
      reqNext   = 1'b0;
      validNext = 1'b0;
      instrNext = RESET_INSTRUCTION;
      misNext   = 1'b0;
      toNext    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.fetchStart) begin
            if (isWordAligned(bus.pcOfInstruction)) begin
              addrNext  = bus.pcOfInstruction;
              reqNext   = 1'b1;
              stateNext = WAIT;
            end else begin
              misNext   = 1'b1;
              stateNext = FAULT;
            end
          end
        end
        WAIT: begin
          // Ack takes priority over a counter expiring in the same cycle.
          if (bus.memReadAck) begin
            instrNext = bus.memReadData;
            pcNext    = addrReg;
            validNext = 1'b1;
            reqNext   = 1'b0;
            stateNext = HOLD;
          end else if (expired) begin
            reqNext   = 1'b0;
            toNext    = 1'b1;
            stateNext = FAULT;
          end
        end
        HOLD: begin
          if (bus.instructionConsume && validReg) begin
            validNext = 1'b0;
            instrNext = RESET_INSTRUCTION;
            stateNext = IDLE;
            // Back-to-back: the new PC goes through the same launch checks.
            if (bus.fetchStart) begin
              if (isWordAligned(bus.pcOfInstruction)) begin
                addrNext  = bus.pcOfInstruction;
                reqNext   = 1'b1;
                stateNext = WAIT;
              end else begin
                misNext   = 1'b1;
                stateNext = FAULT;
              end
            end
          end
        end
        FAULT: begin
          reqNext   = 1'b0;
          validNext = 1'b0;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign bus.memReadAddress   = addrReg;
  assign bus.memReadRequest   = reqReg;
  assign bus.instruction      = instrReg;
  assign bus.instructionPC    = pcReg;
  assign bus.instructionValid = validReg;
  assign bus.fetchMisaligned  = misReg;
  assign bus.fetchTimeout     = toReg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch with a scoreboard of expected words.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } expect_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  expect_t sb[$];

  instruction_fetch_if bus();

  instruction_fetch #(
    .RESET_INSTRUCTION(NOP),
    .ACK_TIMEOUT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    bus.pcOfInstruction    = '0;
    bus.fetchStart         = 1'b0;
    bus.flush              = 1'b0;
    bus.memReadAck         = 1'b0;
    bus.memReadData        = '0;
    bus.instructionConsume = 1'b0;
  endtask

  // Launch a fetch from IDLE; afterwards the first request cycle is current.
  task automatic startFetch(input logic [31:0] pc);
    bus.pcOfInstruction = pc;
    bus.fetchStart = 1'b1;
    step();
    bus.fetchStart = 1'b0;
    checks++;
    if (bus.memReadRequest !== 1'b1 || bus.memReadAddress !== pc) begin
      failures++;
      $display("FAIL start_req pc=%h: req=%b addr=%h, required req=1 addr=%h",
               pc, bus.memReadRequest, bus.memReadAddress, pc);
    end
  endtask

  // Keep ack low for lat request cycles, then acknowledge with data.
  task automatic ackAfter(input logic [31:0] pc, input logic [31:0] data, input int lat);
    for (int i = 0; i < lat; i++) begin
      checks++;
      if (bus.memReadRequest !== 1'b1 || bus.instructionValid !== 1'b0) begin
        failures++;
        $display("FAIL wait_hold pc=%h cycle=%0d: req=%b valid=%b, required req=1 valid=0",
                 pc, i, bus.memReadRequest, bus.instructionValid);
      end
      step();
    end
    bus.memReadAck  = 1'b1;
    bus.memReadData = data;
    sb.push_back('{pc: pc, data: data});
    step();
    bus.memReadAck = 1'b0;
  endtask

  task automatic checkOutput(input string name);
    expect_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: output valid=%b with empty scoreboard, required an expected entry",
               name, bus.instructionValid);
    end else begin
      e = sb.pop_front();
      if (bus.instructionValid !== 1'b1 || bus.instruction !== e.data ||
          bus.instructionPC !== e.pc || bus.memReadRequest !== 1'b0) begin
        failures++;
        $display("FAIL %s: valid=%b instr=%h pc=%h req=%b, required valid=1 instr=%h pc=%h req=0",
                 name, bus.instructionValid, bus.instruction, bus.instructionPC,
                 bus.memReadRequest, e.data, e.pc);
      end
    end
  endtask

  task automatic consumeOne();
    bus.instructionConsume = 1'b1;
    step();
    bus.instructionConsume = 1'b0;
    checks++;
    if (bus.instructionValid !== 1'b0 || bus.instruction !== NOP || bus.memReadRequest !== 1'b0) begin
      failures++;
      $display("FAIL consume: valid=%b instr=%h req=%b, required valid=0 instr=%h req=0",
               bus.instructionValid, bus.instruction, bus.memReadRequest, NOP);
    end
  endtask

  task automatic test_reset();
    idleInputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (bus.memReadRequest !== 1'b0 || bus.memReadAddress !== 32'h0 || bus.instruction !== NOP ||
        bus.instructionPC !== 32'h0 || bus.instructionValid !== 1'b0 ||
        bus.fetchMisaligned !== 1'b0 || bus.fetchTimeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: req=%b addr=%h instr=%h pc=%h valid=%b mis=%b to=%b, required 0/0/%h/0/0/0/0",
               bus.memReadRequest, bus.memReadAddress, bus.instruction, bus.instructionPC,
               bus.instructionValid, bus.fetchMisaligned, bus.fetchTimeout, NOP);
    end
    step();
    startFetch(32'h100);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.memReadRequest !== 1'b0 || bus.memReadAddress !== 32'h0) begin
      failures++;
      $display("FAIL reset_async: req=%b addr=%h, required req=0 addr=0",
               bus.memReadRequest, bus.memReadAddress);
    end
    #2 reset = 1'b0;
    step();
    step();
    checks++;
    if (bus.memReadRequest !== 1'b0 || bus.instructionValid !== 1'b0 || bus.instruction !== NOP) begin
      failures++;
      $display("FAIL reset_mid_wait: req=%b valid=%b instr=%h, required req=0 valid=0 instr=%h",
               bus.memReadRequest, bus.instructionValid, bus.instruction, NOP);
    end
  endtask

  task automatic test_basic_fetch();
    startFetch(32'h40);
    ackAfter(32'h40, 32'h0050_0093, 0);
    checkOutput("basic_first");
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.instructionValid !== 1'b1 || bus.instruction !== 32'h0050_0093 ||
          bus.instructionPC !== 32'h40) begin
        failures++;
        $display("FAIL basic_hold cycle=%0d: valid=%b instr=%h pc=%h, required valid=1 instr=00500093 pc=00000040",
                 i, bus.instructionValid, bus.instruction, bus.instructionPC);
      end
    end
    consumeOne();
    startFetch(32'h1000);
    ackAfter(32'h1000, 32'hFFFF_FFFF, 2);
    checkOutput("basic_lat2");
    consumeOne();
  endtask

  task automatic test_misaligned();
    bus.pcOfInstruction = 32'h42;
    bus.fetchStart = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.fetchMisaligned !== 1'b1 || bus.memReadRequest !== 1'b0) begin
        failures++;
        $display("FAIL misaligned cycle=%0d: mis=%b req=%b, required mis=1 req=0",
                 i, bus.fetchMisaligned, bus.memReadRequest);
      end
    end
    bus.fetchStart = 1'b0;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++;
    if (bus.fetchMisaligned !== 1'b0) begin
      failures++;
      $display("FAIL mis_flush: mis=%b, required 0", bus.fetchMisaligned);
    end
    startFetch(32'h44);
    ackAfter(32'h44, 32'h0000_8067, 1);
    checkOutput("after_mis");
    consumeOne();
  endtask

  task automatic test_timeout();
    int reqCycles;
    startFetch(32'h80);
    reqCycles = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.memReadRequest === 1'b1) reqCycles++;
    end
    checks++;
    if (reqCycles != 4 || bus.fetchTimeout !== 1'b1 || bus.memReadRequest !== 1'b0) begin
      failures++;
      $display("FAIL timeout: reqCycles=%0d to=%b req=%b, required reqCycles=4 to=1 req=0",
               reqCycles, bus.fetchTimeout, bus.memReadRequest);
    end
    bus.pcOfInstruction = 32'h90;
    bus.fetchStart = 1'b1;
    step();
    bus.fetchStart = 1'b0;
    checks++;
    if (bus.memReadRequest !== 1'b0 || bus.fetchTimeout !== 1'b1) begin
      failures++;
      $display("FAIL fault_ignores_start: req=%b to=%b, required req=0 to=1",
               bus.memReadRequest, bus.fetchTimeout);
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    startFetch(32'h84);
    ackAfter(32'h84, 32'hABCD_0123, 3);
    checkOutput("ack_on_last_cycle");
    checks++;
    if (bus.fetchTimeout !== 1'b0) begin
      failures++;
      $display("FAIL ack_wins_timeout: to=%b, required 0", bus.fetchTimeout);
    end
    consumeOne();
  endtask

  task automatic test_back_to_back();
    startFetch(32'h40);
    ackAfter(32'h40, 32'h1111_0001, 0);
    checkOutput("b2b_first");
    bus.instructionConsume = 1'b1;
    bus.fetchStart = 1'b1;
    bus.pcOfInstruction = 32'h48;
    step();
    bus.instructionConsume = 1'b0;
    bus.fetchStart = 1'b0;
    checks++;
    if (bus.instructionValid !== 1'b0 || bus.memReadRequest !== 1'b1 ||
        bus.memReadAddress !== 32'h48 || bus.instruction !== NOP) begin
      failures++;
      $display("FAIL b2b_launch: valid=%b req=%b addr=%h instr=%h, required valid=0 req=1 addr=00000048 instr=%h",
               bus.instructionValid, bus.memReadRequest, bus.memReadAddress, bus.instruction, NOP);
    end
    ackAfter(32'h48, 32'h2222_0002, 3);
    checkOutput("b2b_second");
    consumeOne();
  endtask

  task automatic test_flush_ack();
    startFetch(32'h60);
    bus.memReadAck = 1'b1;
    bus.memReadData = 32'hDEAD_BEEF;
    bus.flush = 1'b1;
    step();
    bus.memReadAck = 1'b0;
    bus.flush = 1'b0;
    checks++;
    if (bus.instructionValid !== 1'b0 || bus.memReadRequest !== 1'b0 || bus.instruction !== NOP) begin
      failures++;
      $display("FAIL flush_ack: valid=%b req=%b instr=%h, required valid=0 req=0 instr=%h",
               bus.instructionValid, bus.memReadRequest, bus.instruction, NOP);
    end
    bus.memReadAck = 1'b1;
    bus.memReadData = 32'h1234_5678;
    step();
    bus.memReadAck = 1'b0;
    checks++;
    if (bus.instructionValid !== 1'b0 || bus.instruction !== NOP) begin
      failures++;
      $display("FAIL stray_ack: valid=%b instr=%h, required valid=0 instr=%h",
               bus.instructionValid, bus.instruction, NOP);
    end
    startFetch(32'h64);
    ackAfter(32'h64, 32'h0000_0073, 1);
    checkOutput("after_flush");
    consumeOne();
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_flush_ack();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
